// File: rtl/vending_credit_fsm.sv
// Clocked vending credit controller: coin accumulation, priced vend, greedy change
// payout over a valid/ready handshake, and an idle auto-refund timeout.
module vending_credit_fsm #(
  parameter int                    CREDIT_W    = 6,
  parameter int                    MAX_CREDIT  = 24,
  parameter int                    NUM_PROD    = 4,
  parameter logic [8*NUM_PROD-1:0] PRICE_TABLE = {8'd12, 8'd5, 8'd8, 8'd3},
  parameter int                    TIMEOUT     = 1000,
  localparam int                   SEL_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          coin_i,
  input  logic                sel_valid_i,
  input  logic [SEL_W-1:0]    sel_i,
  input  logic                return_req_i,
  input  logic                chg_ready_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                vend_o,
  output logic [SEL_W-1:0]    vend_id_o,
  output logic                coin_reject_o,
  output logic                denied_o,
  output logic                chg_valid_o,
  output logic [1:0]          chg_coin_o,
  output logic                busy_o
);

  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SEL_W:0] NUM_PROD_L = (SEL_W + 1)'(NUM_PROD);
  localparam logic [CREDIT_W:0] MAX_CREDIT_L = (CREDIT_W + 1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] CREDIT_ZERO = CREDIT_W'(0);

  typedef enum logic {S_IDLE = 1'b0, S_CHANGE = 1'b1} state_e;

  function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   return (CREDIT_W + 1)'(1);
      2'b10:   return (CREDIT_W + 1)'(2);
      2'b11:   return (CREDIT_W + 1)'(5);
      default: return (CREDIT_W + 1)'(0);
    endcase
  endfunction

  // Largest coin not exceeding the remaining credit.
  function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5)) begin
      return 2'b11;
    end else if (c >= CREDIT_W'(2)) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

  function automatic logic [7:0] price_of(input logic [SEL_W-1:0] s);
    logic [7:0] p;
    p = 8'd0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (s == SEL_W'(i)) begin
        p = PRICE_TABLE[8*i +: 8];
      end
    end
    return p;
  endfunction

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [TIMER_W-1:0]  timer_q;
  logic                vend_q;
  logic [SEL_W-1:0]    vend_id_q;
  logic                coin_reject_q;
  logic                denied_q;
  logic                chg_valid_q;
  logic [1:0]          chg_coin_q;
  logic                busy_q;

  logic [CREDIT_W:0]   sum_s;
  logic                coin_fits_s;
  logic                coin_present_s;
  logic [7:0]          price_s;
  logic                can_vend_s;
  logic [CREDIT_W-1:0] remainder_s;
  logic [CREDIT_W-1:0] credit_after_chg_s;

  // Datapath: one-bit-wider coin sum, price lookup, affordability and remainders.
  always_comb begin
    coin_present_s     = (coin_i != 2'b00);
    sum_s              = {1'b0, credit_q} + coin_value(coin_i);
    coin_fits_s        = (sum_s <= MAX_CREDIT_L);
    price_s            = price_of(sel_i);
    can_vend_s         = ({1'b0, sel_i} < NUM_PROD_L) &&
                         ((CREDIT_W + 8)'(credit_q) >= (CREDIT_W + 8)'(price_s));
    remainder_s        = credit_q - CREDIT_W'(price_s);
    credit_after_chg_s = credit_q - CREDIT_W'(coin_value(chg_coin_q));
  end

  // Main controller: IDLE priority is refund, then select, then coin, then timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      credit_q      <= CREDIT_ZERO;
      timer_q       <= TIMER_W'(0);
      vend_q        <= 1'b0;
      vend_id_q     <= SEL_W'(0);
      coin_reject_q <= 1'b0;
      denied_q      <= 1'b0;
      chg_valid_q   <= 1'b0;
      chg_coin_q    <= 2'b00;
      busy_q        <= 1'b0;
    end else begin
      vend_q        <= 1'b0;
      denied_q      <= 1'b0;
      coin_reject_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (return_req_i) begin
            coin_reject_q <= coin_present_s;
            if (credit_q != CREDIT_ZERO) begin
              state_q     <= S_CHANGE;
              chg_valid_q <= 1'b1;
              chg_coin_q  <= greedy_coin(credit_q);
              busy_q      <= 1'b1;
              timer_q     <= TIMER_W'(0);
            end else begin
              timer_q     <= TIMER_W'(0);
            end
          end else if (sel_valid_i) begin
            coin_reject_q <= coin_present_s;
            timer_q       <= TIMER_W'(0);
            if (can_vend_s) begin
              vend_q    <= 1'b1;
              vend_id_q <= sel_i;
              credit_q  <= remainder_s;
              if (remainder_s != CREDIT_ZERO) begin
                state_q     <= S_CHANGE;
                chg_valid_q <= 1'b1;
                chg_coin_q  <= greedy_coin(remainder_s);
                busy_q      <= 1'b1;
              end else begin
                state_q     <= S_IDLE;
              end
            end else begin
              denied_q <= 1'b1;
            end
          end else if (coin_present_s && coin_fits_s) begin
            credit_q <= sum_s[CREDIT_W-1:0];
            timer_q  <= TIMER_W'(0);
          end else begin
            // A rejected coin lands here too, so it never restarts the idle count.
            coin_reject_q <= coin_present_s;
            if ((TIMEOUT != 0) && (credit_q != CREDIT_ZERO)) begin
              if (timer_q == TIMER_LAST) begin
                state_q     <= S_CHANGE;
                chg_valid_q <= 1'b1;
                chg_coin_q  <= greedy_coin(credit_q);
                busy_q      <= 1'b1;
                timer_q     <= TIMER_W'(0);
              end else begin
                timer_q <= timer_q + TIMER_W'(1);
              end
            end else begin
              timer_q <= TIMER_W'(0);
            end
          end
        end
        S_CHANGE: begin
          coin_reject_q <= coin_present_s;
          denied_q      <= sel_valid_i;
          if (chg_ready_i) begin
            credit_q <= credit_after_chg_s;
            if (credit_after_chg_s == CREDIT_ZERO) begin
              state_q     <= S_IDLE;
              chg_valid_q <= 1'b0;
              chg_coin_q  <= 2'b00;
              busy_q      <= 1'b0;
            end else begin
              chg_coin_q  <= greedy_coin(credit_after_chg_s);
            end
          end else begin
            chg_coin_q <= chg_coin_q;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          chg_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign credit_o      = credit_q;
  assign vend_o        = vend_q;
  assign vend_id_o     = vend_id_q;
  assign coin_reject_o = coin_reject_q;
  assign denied_o      = denied_q;
  assign chg_valid_o   = chg_valid_q;
  assign chg_coin_o    = chg_coin_q;
  assign busy_o        = busy_q;

endmodule

// File: doc/vending_credit_fsm.md
# vending_credit_fsm

Clocked, parametrised successor to the combinational credit next-state logic in the vending machine. It holds credit in 5-cent units and accepts nickel, dime and quarter coins. It vends from a configurable price table and pays change back as a sequence of coins over a valid/ready handshake. It adds things the combinational version lacked: an idle auto-refund timeout, plus explicit reject and deny pulses.

## Interface
Parameters:
- CREDIT_W, 6: width of the credit register, in 5-cent units.
- MAX_CREDIT, 24: maximum credit in units (24 = 120c). Must be < 2^CREDIT_W.
- NUM_PROD, 4: number of products.
- PRICE_TABLE, {8'd12,8'd5,8'd8,8'd3}: packed prices in units. Product i occupies bits [8i+7:8i], so P0=3, P1=8, P2=5, P3=12. Each price is nonzero and ≤ MAX_CREDIT.
- TIMEOUT, 1000: idle cycles before auto-refund. 0 disables the timeout.

Ports:
- CLK  in  1  clock. All state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- COIN  in  2  coin inserted this cycle: 00 none, 01 nickel (1 unit), 10 dime (2), 11 quarter (5).
- SEL_VALID  in  1  product-select strobe.
- SEL  in  max(1,$clog2(NUM_PROD))  product index. Qualified by SEL_VALID.
- RETURN_REQ  in  1  refund request.
- CHG_READY  in  1  payout mechanism accepts the current CHG_COIN.
- CREDIT  out  CREDIT_W  current credit in units.
- VEND  out  1  one-cycle pulse: a product is dispensed.
- VEND_ID  out  same as SEL  index of the vended product. Valid with VEND, holds its last value otherwise.
- COIN_REJECT  out  1  one-cycle pulse: the inserted coin was not credited.
- DENIED  out  1  one-cycle pulse: the select was refused.
- CHG_VALID  out  1  a change coin is offered.
- CHG_COIN  out  2  denomination offered, same encoding as COIN.
- BUSY  out  1  high while the block is in CHANGE.

## Operation
- Two states: IDLE and CHANGE. All outputs are registered.
- Reset (async, RST_N=0): state IDLE, CREDIT 0, timer 0, VEND_ID 0, CHG_COIN 00. All pulse outputs, CHG_VALID and BUSY are 0. A reset during a payout discards the remaining credit.
- IDLE priority, evaluated per cycle: RETURN_REQ first, then SEL_VALID, then COIN.
  - RETURN_REQ: if CREDIT > 0, go to CHANGE. If CREDIT = 0, do nothing.
  - SEL_VALID, SEL < NUM_PROD and CREDIT ≥ price: pulse VEND, latch VEND_ID=SEL, CREDIT -= price. If the remainder is > 0, go to CHANGE. If it is 0, stay in IDLE.
  - SEL_VALID and (SEL ≥ NUM_PROD or CREDIT < price): pulse DENIED. CREDIT is unchanged.
  - COIN ≠ 00 alone: if CREDIT + value ≤ MAX_CREDIT, add the value. Otherwise pulse COIN_REJECT.
  - COIN ≠ 00 in the same cycle as RETURN_REQ or SEL_VALID: pulse COIN_REJECT, no credit.
- CHANGE:
  - Greedy denomination: quarter if CREDIT ≥ 5, else dime if CREDIT ≥ 2, else nickel.
  - On each edge with CHG_VALID & CHG_READY: CREDIT -= the value of CHG_COIN, and CHG_COIN is recomputed from the new credit.
  - When the new credit reaches 0: CHG_VALID=0, go to IDLE.
  - Any COIN ≠ 00 pulses COIN_REJECT.
  - SEL_VALID pulses DENIED. RETURN_REQ is ignored.
- Timeout counter:
  - Counts only in IDLE with CREDIT > 0.
  - Clears on any accepted coin, vend, DENIED, or on entering CHANGE.
  - On reaching TIMEOUT, go to CHANGE. A rejected coin does not clear it.
- Arithmetic: the sum is computed at CREDIT_W+1 bits before comparing with MAX_CREDIT, so there is no wrap. Subtraction is guarded by the ≥ test, so there is no underflow.

## Timing
- Inputs are sampled on rising edge N. VEND, DENIED, COIN_REJECT and the CREDIT update are visible after edge N, and pulses last exactly one cycle.
- Entering CHANGE at edge N: BUSY=1, CHG_VALID=1 and a valid CHG_COIN are all present after edge N. This is the same cycle as a VEND pulse.
- CHG_COIN and CHG_VALID stay stable while CHG_READY=0. Payout throughput is one coin per cycle when CHG_READY is held high.
- Return to IDLE: BUSY=0 and CHG_VALID=0 after the handshake edge that zeroes CREDIT. The next coin can be accepted on the following edge.
- Timeout: with credit last changed at edge N, CHANGE is entered at edge N+TIMEOUT.

## Test plan
- Reset, then quarter, dime, nickel on consecutive cycles → CREDIT 5, 7, 8. Then SEL=1 → VEND pulse with VEND_ID=1, CREDIT 0, CHG_VALID never asserted.
- Quarter, quarter, dime (CREDIT 12), then SEL=0 → VEND and CREDIT 9. Payout is quarter, dime, dime with CHG_READY toggled every other cycle. CHG_COIN must hold stable while not ready. CREDIT goes 9→4→2→0, then BUSY=0.
- Four quarters (20), then a quarter → COIN_REJECT with CREDIT still 20. A dime → 22. A dime → 24. A nickel → COIN_REJECT.
- CREDIT 2: SEL=1 → DENIED, CREDIT 2. SEL=3 with CREDIT 24 → vend, change 12. SEL=4 with NUM_PROD=5 and price 0 is not allowed, so check SEL out of range with NUM_PROD=3 → DENIED.
- TIMEOUT=16: dime, then idle → CHG_VALID with a dime exactly 16 edges later. A nickel inserted at cycle 10 restarts the count, and the payout is then a dime followed by a nickel.
- RETURN_REQ, SEL_VALID and a quarter in the same cycle → refund starts, COIN_REJECT pulses, no VEND. RST_N dropped mid-payout → CHG_VALID, BUSY and CREDIT go to 0 immediately, without waiting for a clock edge.
